// File: rtl/iir_output_quantizer.sv
// iir_output_quantizer: rounds/saturates the Q31.32 sign-magnitude filter result to an
// OUT_W-bit two's-complement word, buffers it in a small FIFO behind valid/ready and keeps
// saturation/drop statistics. The upstream filter cannot be stalled; overflow drops samples.
module iir_output_quantizer #(
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned FRAC_OUT   = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      y_i,
  input  logic             y_valid_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  input  logic             clr_stats_i,
  output logic [CNT_W-1:0] sat_count_o,
  output logic [CNT_W-1:0] drop_count_o,
  output logic             ovf_o
);

  // Truncated magnitude spans mag[62:32-FRAC_OUT]; one extra bit absorbs the rounding carry.
  localparam int unsigned T_W   = 31 + FRAC_OUT;
  localparam int unsigned M_W   = T_W + 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = AW + 1;
  localparam logic [M_W-1:0] MAX_M = M_W'((64'd1 << (OUT_W - 1)) - 64'd1);

  // S1 keeps only the sign, the kept magnitude bits and the rounding bit.
  logic             r_s1_valid;
  logic             r_s1_sign;
  logic [T_W:0]     r_s1_mag;
  logic             r_s2_valid;
  logic [OUT_W-1:0] r_s2_data;

  logic [OUT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_sat_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             r_ovf;

  logic [M_W-1:0]   w_mag;
  logic             w_sat;
  logic [OUT_W-1:0] w_mag_q;
  logic [OUT_W-1:0] w_word;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  // Fraction bits below the rounding bit never influence the result.
  if (FRAC_OUT < 31) begin : g_lsb
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^y_i[30-FRAC_OUT:0];
  end

  // Round half away from zero on the magnitude, clamp symmetrically, then apply the sign.
  always_comb begin
    w_mag   = M_W'(r_s1_mag[T_W:1]) + M_W'(r_s1_mag[0]);
    w_sat   = (w_mag > MAX_M);
    w_mag_q = w_sat ? OUT_W'(MAX_M) : OUT_W'(w_mag);
    w_word  = r_s1_sign ? (OUT_W'(0) - w_mag_q) : w_mag_q;
  end

  // FIFO status and the push/pop/drop decision for the E2 write.
  always_comb begin
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_pop   = !w_empty && out_ready_i;
    w_push  = r_s2_valid && (!w_full || w_pop);
    w_drop  = r_s2_valid && w_full && !w_pop;
  end

  // Two-stage pipeline: capture (S1) and quantized word (S2).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_mag   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else begin
      r_s1_valid <= y_valid_i;
      if (y_valid_i) begin
        r_s1_sign <= y_i[63];
        r_s1_mag  <= y_i[62:31-FRAC_OUT];
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_word;
      end
    end
  end

  // Output FIFO storage and pointers; a full FIFO still accepts when the head pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= r_s2_data;
        r_wr_ptr                <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // Saturating statistics; a clear pulse overrides any coincident event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_cnt  <= '0;
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
    end else if (clr_stats_i) begin
      r_sat_cnt  <= '0;
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (r_s1_valid && w_sat && (r_sat_cnt != '1)) begin
        r_sat_cnt <= r_sat_cnt + CNT_W'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign out_data_o   = r_mem[r_rd_ptr[AW-1:0]];
  assign out_valid_o  = !w_empty;
  assign sat_count_o  = r_sat_cnt;
  assign drop_count_o = r_drop_cnt;
  assign ovf_o        = r_ovf;

endmodule

// File: tb/tb_iir_output_quantizer.sv
// Bench for iir_output_quantizer: directed vector table, hand-written FIFO/reset sequences,
// and randomized traffic checked against a queue-based behavioural model.
module tb_iir_output_quantizer;

  localparam int unsigned OUT_W      = 16;
  localparam int unsigned FRAC_OUT   = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W      = 16;
  localparam longint unsigned MAXV   = 32767;
  localparam int CNT_MAX             = 65535;

  logic             clk = 1'b0;
  logic             rst;
  logic [63:0]      y_i;
  logic             y_valid_i;
  logic [OUT_W-1:0] out_data_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             clr_stats_i;
  logic [CNT_W-1:0] sat_count_o;
  logic [CNT_W-1:0] drop_count_o;
  logic             ovf_o;

  int n_checks = 0;
  int n_fail   = 0;

  iir_output_quantizer #(
    .OUT_W(OUT_W), .FRAC_OUT(FRAC_OUT), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .y_i(y_i), .y_valid_i(y_valid_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .clr_stats_i(clr_stats_i), .sat_count_o(sat_count_o), .drop_count_o(drop_count_o),
    .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] y;
    logic [15:0] word;
    int          sat;
  } vec_t;

  vec_t vecs[11];

  // Behavioural model state: two-slot delay line, FIFO as queue, plain counters.
  bit          m_p1_v, m_p2_v, m_p1_s;
  logic [15:0] m_p1_w, m_p2_w;
  logic [15:0] m_fifo[$];
  int          m_sat, m_drop;
  bit          m_ovf;

  // Quantize by integer division: round(|y| / 2^(32-FRAC_OUT)) half away from zero.
  function automatic logic [16:0] quant(input logic [63:0] y);
    longint unsigned mag, dv, q, rem;
    logic [15:0] w;
    bit s;
    mag = {1'b0, y[62:0]};
    dv  = 64'd1 << (32 - FRAC_OUT);
    q   = mag / dv;
    rem = mag % dv;
    if (rem * 2 >= dv) q++;
    s = (q > MAXV);
    if (s) q = MAXV;
    w = 16'(q);
    if (y[63]) w = 16'd0 - w;
    return {s, w};
  endfunction

  task automatic model_reset();
    m_p1_v = 0; m_p2_v = 0; m_p1_s = 0; m_p1_w = '0; m_p2_w = '0;
    m_fifo.delete();
    m_sat = 0; m_drop = 0; m_ovf = 0;
  endtask

  task automatic model_update();
    bit pop, drop;
    pop  = (m_fifo.size() > 0) && out_ready_i;
    drop = 0;
    if (pop) void'(m_fifo.pop_front());
    if (m_p2_v) begin
      if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(m_p2_w);
      else drop = 1;
    end
    if (clr_stats_i) begin
      m_sat = 0; m_drop = 0; m_ovf = 0;
    end else begin
      if (m_p1_v && m_p1_s && m_sat < CNT_MAX) m_sat++;
      if (drop) begin
        if (m_drop < CNT_MAX) m_drop++;
        m_ovf = 1;
      end
    end
    m_p2_v = m_p1_v;
    m_p2_w = m_p1_w;
    m_p1_v = y_valid_i;
    if (y_valid_i) {m_p1_s, m_p1_w} = quant(y_i);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_update();
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_model(input string tag);
    check({tag, "_valid"}, 64'(out_valid_o), 64'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) check({tag, "_data"}, 64'(out_data_o), 64'(m_fifo[0]));
    check({tag, "_sat"}, 64'(sat_count_o), 64'(m_sat));
    check({tag, "_drop"}, 64'(drop_count_o), 64'(m_drop));
    check({tag, "_ovf"}, 64'(ovf_o), 64'(m_ovf));
  endtask

  task automatic push_word(input int w);
    y_i = 64'(w) << (32 - FRAC_OUT);
    y_valid_i = 1'b1;
    tick();
    y_valid_i = 1'b0;
  endtask

  initial begin
    logic [15:0] got[$];
    logic [15:0] expq[$];
    int exp_sat;

    vecs[0]  = '{64'h0000_0001_8000_0000, 16'h0180, 0};
    vecs[1]  = '{64'h8000_0000_0280_0000, 16'hFFFD, 0};
    vecs[2]  = '{64'h0000_0000_027F_FFFF, 16'h0002, 0};
    vecs[3]  = '{64'h0000_00C8_0000_0000, 16'h7FFF, 1};
    vecs[4]  = '{64'h8000_00C8_0000_0000, 16'h8001, 1};
    vecs[5]  = '{64'h8000_0000_0000_0000, 16'h0000, 0};
    vecs[6]  = '{64'h8000_0000_0080_0000, 16'hFFFF, 0};
    vecs[7]  = '{64'h8000_0000_007F_FFFF, 16'h0000, 0};
    vecs[8]  = '{64'h0000_007F_FF00_0000, 16'h7FFF, 0};
    vecs[9]  = '{64'h0000_007F_FF80_0000, 16'h7FFF, 1};
    vecs[10] = '{64'h8000_007F_FF00_0000, 16'h8001, 0};

    rst = 1'b1; y_i = '0; y_valid_i = 1'b0; out_ready_i = 1'b0; clr_stats_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_data", 64'(out_data_o), 64'd0);
    check("rst_sat", 64'(sat_count_o), 64'd0);
    check("rst_drop", 64'(drop_count_o), 64'd0);
    check("rst_ovf", 64'(ovf_o), 64'd0);
    rst = 1'b0;

    // Directed rounding/saturation vectors, one at a time, with latency checks.
    out_ready_i = 1'b1;
    exp_sat = 0;
    for (int i = 0; i < 11; i++) begin
      y_i = vecs[i].y;
      y_valid_i = 1'b1;
      tick();
      y_valid_i = 1'b0;
      y_i = 64'hDEAD_BEEF_DEAD_BEEF;
      tick();
      check("vec_lat_early", 64'(out_valid_o), 64'd0);
      tick();
      exp_sat += vecs[i].sat;
      check("vec_valid", 64'(out_valid_o), 64'd1);
      check("vec_data", 64'(out_data_o), 64'(vecs[i].word));
      check("vec_sat", 64'(sat_count_o), 64'(exp_sat));
      cmp_model("vec");
      tick();
      check("vec_popped", 64'(out_valid_o), 64'd0);
    end

    // Overflow: five samples into a stalled 4-entry FIFO.
    out_ready_i = 1'b0;
    for (int k = 1; k <= 5; k++) push_word(k);
    repeat (3) tick();
    check("ovf_drop", 64'(drop_count_o), 64'd1);
    check("ovf_flag", 64'(ovf_o), 64'd1);
    cmp_model("ovf");
    out_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("ovf_valid", 64'(out_valid_o), 64'd1);
      check("ovf_order", 64'(out_data_o), 64'(k));
      tick();
    end
    check("ovf_empty", 64'(out_valid_o), 64'd0);
    clr_stats_i = 1'b1;
    tick();
    clr_stats_i = 1'b0;
    check("clr_sat", 64'(sat_count_o), 64'd0);
    check("clr_drop", 64'(drop_count_o), 64'd0);
    check("clr_ovf", 64'(ovf_o), 64'd0);
    cmp_model("clr");

    // Full FIFO drained while streaming: no drops, one word per cycle, order kept.
    out_ready_i = 1'b0;
    for (int k = 10; k <= 13; k++) begin
      push_word(k);
      expq.push_back(16'(k));
    end
    repeat (3) tick();
    check("full_cnt", 64'(m_fifo.size()), 64'(FIFO_DEPTH));
    out_ready_i = 1'b1;
    for (int k = 20; k < 36; k++) begin
      if (out_valid_o) got.push_back(out_data_o);
      check("stream_valid", 64'(out_valid_o), 64'd1);
      y_i = 64'(k) << (32 - FRAC_OUT);
      y_valid_i = 1'b1;
      expq.push_back(16'(k));
      tick();
      cmp_model("stream");
    end
    y_valid_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid_o) got.push_back(out_data_o);
      tick();
    end
    check("stream_drop", 64'(drop_count_o), 64'd0);
    check("stream_count", 64'(got.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      check("stream_order", 64'(got[i]), 64'(expq[i]));

    // Asynchronous reset with three buffered entries and two in flight.
    out_ready_i = 1'b0;
    y_i = 64'h0000_00C8_0000_0000;
    y_valid_i = 1'b1;
    tick();
    push_word(1);
    push_word(2);
    repeat (3) tick();
    check("prerst_sat", 64'(sat_count_o), 64'd1);
    check("prerst_valid", 64'(out_valid_o), 64'd1);
    push_word(3);
    push_word(4);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid_o), 64'd0);
    check("arst_sat", 64'(sat_count_o), 64'd0);
    check("arst_drop", 64'(drop_count_o), 64'd0);
    check("arst_data", 64'(out_data_o), 64'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("postrst_valid", 64'(out_valid_o), 64'd0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic [30:0] ip;
      case ($urandom_range(0, 3))
        0: ip = '0;
        1: ip = 31'($urandom_range(0, 130));
        2: ip = 31'($urandom);
        default: ip = 31'd127;
      endcase
      y_i = {1'($urandom_range(0, 1)), ip, 32'($urandom)};
      y_valid_i = ($urandom_range(0, 9) < 7);
      out_ready_i = ($urandom_range(0, 9) < 6);
      clr_stats_i = ($urandom_range(0, 39) == 0);
      tick();
      cmp_model("rand");
    end
    y_valid_i = 1'b0;
    clr_stats_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
